regfile_mp_sb: RTL and testbench

//  Multi-port integer register file for the pipelined RV32I core; successor of the single-issue regfile.

---
 rtl/rv32i_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_mp_sb.sv | 97 +++++++++
 tb/tb_regfile_mp_sb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I integer-datapath constants and types.
package rv32i_pkg;

    localparam int REG_W    = 32;
    localparam int REG_N    = 32;
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: decode reserves a destination register, writeback releases it.
import rv32i_pkg::*;

module rf_scoreboard #(
    parameter int DEPTH = REG_N,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ready,
    output logic [DEPTH-1:0]  busy,
    output logic [AW:0]       busy_cnt
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] release_vec;
    logic [AW:0]      cnt_q, cnt_d;

    // A release of the requested register in the same cycle unblocks the
    // reservation; the reserve is applied after the release so it wins.
    always_comb begin
        release_vec = '0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j]) begin
                release_vec[wr_addr[j*AW +: AW]] = 1'b1;
            end
        end

        rsv_ready = !rst && (rsv_addr == '0 || !busy_q[rsv_addr] || release_vec[rsv_addr]);

        busy_d = busy_q & ~release_vec;
        if (rsv_valid && rsv_ready && rsv_addr != '0) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a busy-bit scoreboard.
import rv32i_pkg::*;

module regfile_mp_sb #(
    parameter int               WIDTH   = REG_W,
    parameter int               DEPTH   = REG_N,
    parameter int               NRD     = 2,
    parameter int               NWR     = 1,
    parameter int               BYPASS  = 1,
    parameter int               SP_IDX  = REG_SP,
    parameter logic [WIDTH-1:0] SP_INIT = '0,
    localparam int              AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_dout,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_din,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    output logic [AW:0]          busy_cnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy;

    // Returns {hit, data} of the highest-index enabled write port targeting ra.
    function automatic logic [WIDTH:0] bypass_lookup(input logic [AW-1:0] ra);
        logic [WIDTH:0] res;
        res = '0;
        for (int j = 0; j < NWR; j++) begin
            if (BYPASS != 0 && we[j] && wr_addr[j*AW +: AW] != '0 && wr_addr[j*AW +: AW] == ra) begin
                res = {1'b1, wr_din[j*WIDTH +: WIDTH]};
            end
        end
        return res;
    endfunction

    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && wr_addr[j*AW +: AW] != '0) begin
                mem_d[wr_addr[j*AW +: AW]] = wr_din[j*WIDTH +: WIDTH];
            end
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        logic [AW-1:0]  ra;
        logic [WIDTH:0] byp;
        ra      = '0;
        byp     = '0;
        rd_dout = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = rd_addr[i*AW +: AW];
            byp = bypass_lookup(ra);
            if (ra != '0) begin
                rd_dout[i*WIDTH +: WIDTH] = byp[WIDTH] ? byp[WIDTH-1:0] : mem_q[ra];
                rd_busy[i]                = busy[ra] & ~byp[WIDTH];
            end
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard-checked bench for regfile_mp_sb with two write ports, bypass on and SP_INIT=20.
module tb_regfile_mp_sb;

    localparam int K_DOUT0 = 0;
    localparam int K_DOUT1 = 1;
    localparam int K_BUSY0 = 2;
    localparam int K_BUSY1 = 3;
    localparam int K_READY = 4;
    localparam int K_CNT   = 5;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_dout;
    logic [1:0]  rd_busy;
    logic [1:0]  we;
    logic [9:0]  wr_addr;
    logic [63:0] wr_din;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic [5:0]  busy_cnt;

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .WIDTH   (32),
        .DEPTH   (32),
        .NRD     (2),
        .NWR     (2),
        .BYPASS  (1),
        .SP_IDX  (2),
        .SP_INIT (32'd20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_dout   (rd_dout),
        .rd_busy   (rd_busy),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_din    (wr_din),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .busy_cnt  (busy_cnt)
    );

    // Monitor: drains every expectation queued for this cycle against the settled outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_DOUT0: act = rd_dout[31:0];
                K_DOUT1: act = rd_dout[63:32];
                K_BUSY0: act = {31'd0, rd_busy[0]};
                K_BUSY1: act = {31'd0, rd_busy[1]};
                K_READY: act = {31'd0, rsv_ready};
                K_CNT:   act = {26'd0, busy_cnt};
                default: act = 'x;
            endcase
            vectors++;
            if (act !== e.val) begin
                miscompares++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
            end
        end
    end

    task automatic applyStimulus(input logic rs, input logic [1:0] we_i,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic rv, input logic [4:0] ra_rsv);
        rst       = rs;
        we        = we_i;
        wr_addr   = {wa1, wa0};
        wr_din    = {wd1, wd0};
        rd_addr   = {ra1, ra0};
        rsv_valid = rv;
        rsv_addr  = ra_rsv;
    endtask

    task automatic checkOutput(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Reset state sweep: only x2 carries SP_INIT
        for (int r = 0; r < 32; r += 2) begin
            applyStimulus(0, 2'b00, 0, 0, 0, 0, 5'(r), 5'(r + 1), 0, 0);
            checkOutput(K_DOUT0, (r == 2) ? 32'd20 : 32'd0, $sformatf("rst_x%0d", r));
            checkOutput(K_DOUT1, 32'd0, $sformatf("rst_x%0d", r + 1));
            checkOutput(K_BUSY0, 32'd0, "rst_busy0");
            checkOutput(K_BUSY1, 32'd0, "rst_busy1");
            if (r == 0) begin
                checkOutput(K_READY, 32'd1, "rst_ready");
                checkOutput(K_CNT, 32'd0, "rst_cnt");
            end
            nextCycle();
        end

        applyStimulus(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 2, 0, 0);
        checkOutput(K_DOUT0, 32'hDEADBEEF, "t2_bypass");
        checkOutput(K_DOUT1, 32'd20, "t2_x2");
        checkOutput(K_BUSY0, 32'd0, "t2_busy_bypass");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 5, 5, 0, 0);
        checkOutput(K_DOUT0, 32'hDEADBEEF, "t2_stored");
        checkOutput(K_BUSY0, 32'd0, "t2_nonbusy_write");
        checkOutput(K_CNT, 32'd0, "t2_cnt");
        nextCycle();

        applyStimulus(0, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 1, 0);
        checkOutput(K_DOUT0, 32'd0, "t3_x0_bypass");
        checkOutput(K_READY, 32'd1, "t3_rsv_x0");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput(K_DOUT0, 32'd0, "t3_x0_stored");
        checkOutput(K_BUSY0, 32'd0, "t3_x0_busy");
        checkOutput(K_CNT, 32'd0, "t3_cnt");
        nextCycle();

        applyStimulus(0, 2'b11, 7, 32'hAAAA, 7, 32'h5555, 7, 5, 0, 0);
        checkOutput(K_DOUT0, 32'h5555, "t4_bypass_prio");
        checkOutput(K_DOUT1, 32'hDEADBEEF, "t4_x5");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0);
        checkOutput(K_DOUT0, 32'h5555, "t4_stored_prio");
        nextCycle();

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 9, 0, 1, 9);
        checkOutput(K_READY, 32'd1, "t5_rsv9");
        checkOutput(K_CNT, 32'd0, "t5_cnt_before");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 9, 0, 1, 9);
        checkOutput(K_BUSY0, 32'd1, "t5_busy9");
        checkOutput(K_CNT, 32'd1, "t5_cnt1");
        checkOutput(K_READY, 32'd0, "t5_waw_stall");
        nextCycle();
        applyStimulus(0, 2'b01, 9, 32'h99, 0, 0, 9, 0, 1, 9);
        checkOutput(K_READY, 32'd1, "t5_release_rsv");
        checkOutput(K_BUSY0, 32'd0, "t5_busy_bypass");
        checkOutput(K_DOUT0, 32'h99, "t5_dout_bypass");
        checkOutput(K_CNT, 32'd1, "t5_cnt_hold");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0);
        checkOutput(K_BUSY0, 32'd1, "t5_reserve_wins");
        checkOutput(K_CNT, 32'd1, "t5_cnt_after");
        checkOutput(K_DOUT0, 32'h99, "t5_x9");
        nextCycle();
        applyStimulus(0, 2'b01, 9, 32'h100, 0, 0, 0, 9, 0, 0);
        checkOutput(K_BUSY1, 32'd0, "t5_busy1_bypass");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 9, 0, 0, 0);
        checkOutput(K_BUSY0, 32'd0, "t5_released");
        checkOutput(K_CNT, 32'd0, "t5_cnt0");
        checkOutput(K_DOUT0, 32'h100, "t5_x9_new");
        nextCycle();

        // Two ports releasing distinct registers in one edge
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 10);
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 11);
        checkOutput(K_READY, 32'd1, "mr_rsv11");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 10, 11, 0, 0);
        checkOutput(K_BUSY0, 32'd1, "mr_busy10");
        checkOutput(K_BUSY1, 32'd1, "mr_busy11");
        checkOutput(K_CNT, 32'd2, "mr_cnt2");
        nextCycle();
        applyStimulus(0, 2'b11, 10, 32'd1, 11, 32'd2, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 10, 11, 0, 0);
        checkOutput(K_BUSY0, 32'd0, "mr_rel10");
        checkOutput(K_BUSY1, 32'd0, "mr_rel11");
        checkOutput(K_CNT, 32'd0, "mr_cnt0");
        checkOutput(K_DOUT0, 32'd1, "mr_x10");
        checkOutput(K_DOUT1, 32'd2, "mr_x11");
        nextCycle();

        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3);
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4);
        checkOutput(K_CNT, 32'd1, "t6_cnt1");
        nextCycle();
        applyStimulus(1, 2'b01, 3, 32'h333, 0, 0, 3, 0, 1, 5);
        checkOutput(K_READY, 32'd0, "t6_ready_in_rst");
        checkOutput(K_CNT, 32'd2, "t6_cnt2");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 3, 2, 0, 0);
        checkOutput(K_DOUT0, 32'd0, "t6_x3_dropped");
        checkOutput(K_DOUT1, 32'd20, "t6_x2_sp");
        checkOutput(K_BUSY0, 32'd0, "t6_busy3");
        checkOutput(K_CNT, 32'd0, "t6_cnt0");
        checkOutput(K_READY, 32'd1, "t6_ready");
        nextCycle();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 5, 7, 0, 0);
        checkOutput(K_DOUT0, 32'd0, "t6_x5_cleared");
        checkOutput(K_DOUT1, 32'd0, "t6_x7_cleared");
        nextCycle();

        nextCycle();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
